// File: rtl/dcsk_chip_sequencer.sv
// dcsk_chip_sequencer
// Chip and symbol sequencer for the DCSK transmit serializer. Each symbol
// consists of a reference half followed by a data half, SF chips each.
// Chips advance only when the chaos source has a chip and the downstream
// path can accept it. The spreading factor is sampled at frame start and
// at every symbol boundary. i_abort ends the frame on the next edge.
module dcsk_chip_sequencer #(
  parameter int SF_W       = 2,
  parameter int FRAME_SYMS = 8,
  localparam int CHIP_W    = (2 ** SF_W) + 1,
  localparam int SYM_W     = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [SF_W-1:0]   i_sf_code,
  input  logic              i_chip_valid,
  input  logic              i_chip_ready,
  output logic              o_chip_take,
  output logic [CHIP_W-1:0] o_chip_index,
  output logic              o_ref_phase,
  output logic [SYM_W-1:0]  o_sym_index,
  output logic [SF_W-1:0]   o_sf_active,
  output logic              o_sym_done,
  output logic              o_frame_done,
  output logic              o_busy
);

  // A frame needs at least one symbol; stop elaboration if it has none.
  if (FRAME_SYMS < 1) begin : g_bad_frame_syms
    $error("dcsk_chip_sequencer: FRAME_SYMS must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CHIP_W-1:0] CHIP_ONES = {CHIP_W{1'b1}};
  localparam logic [CHIP_W-1:0] CHIP_ONE  = {{(CHIP_W-1){1'b0}}, 1'b1};
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(FRAME_SYMS - 1);

  state_t            state;
  logic [CHIP_W-1:0] chip_last;
  logic [CHIP_W-1:0] sf_size;

  // The last chip index is 2*SF-1 = 2^(code+2)-1. Building it as the low
  // bits of an all-ones mask keeps it exact at CHIP_W bits, even for the
  // largest code where 2*SF itself does not fit.
  always_comb begin
    chip_last = ~(CHIP_ONES << (int'(o_sf_active) + 2));
    sf_size   = CHIP_ONE << (int'(o_sf_active) + 1);
  end

  assign o_busy      = (state == RUN);
  assign o_chip_take = o_busy & i_chip_valid & i_chip_ready & ~i_abort;
  assign o_ref_phase = o_busy & (o_chip_index < sf_size);

  // Frame FSM with chip/symbol counters; abort overrides everything and
  // returns to IDLE with cleared counters but keeps the latched SF code.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= IDLE;
      o_chip_index <= '0;
      o_sym_index  <= '0;
      o_sf_active  <= '0;
      o_sym_done   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_sym_done   <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_abort) begin
        state        <= IDLE;
        o_chip_index <= '0;
        o_sym_index  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state        <= RUN;
              o_sf_active  <= i_sf_code;
              o_chip_index <= '0;
              o_sym_index  <= '0;
            end
          end
          RUN: begin
            if (o_chip_take) begin
              if (o_chip_index == chip_last) begin
                o_chip_index <= '0;
                o_sf_active  <= i_sf_code;
                o_sym_done   <= 1'b1;
                if (o_sym_index == SYM_LAST) begin
                  o_sym_index  <= '0;
                  state        <= IDLE;
                  o_frame_done <= 1'b1;
                end else begin
                  o_sym_index <= o_sym_index + 1'b1;
                end
              end else begin
                o_chip_index <= o_chip_index + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcsk_chip_sequencer.sv
// tb_dcsk_chip_sequencer
// Directed bench for dcsk_chip_sequencer with default parameters
// (SF_W=2, FRAME_SYMS=8). Inputs change 1 time unit after a rising edge
// and outputs are sampled 1 time unit after that.
module tb_dcsk_chip_sequencer;

  logic       i_clk;
  logic       i_arst_n;
  logic       i_start;
  logic       i_abort;
  logic [1:0] i_sf_code;
  logic       i_chip_valid;
  logic       i_chip_ready;
  logic       o_chip_take;
  logic [4:0] o_chip_index;
  logic       o_ref_phase;
  logic [2:0] o_sym_index;
  logic [1:0] o_sf_active;
  logic       o_sym_done;
  logic       o_frame_done;
  logic       o_busy;

  int checks;
  int errors;

  dcsk_chip_sequencer #(.SF_W(2), .FRAME_SYMS(8)) dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_sf_code    (i_sf_code),
    .i_chip_valid (i_chip_valid),
    .i_chip_ready (i_chip_ready),
    .o_chip_take  (o_chip_take),
    .o_chip_index (o_chip_index),
    .o_ref_phase  (o_ref_phase),
    .o_sym_index  (o_sym_index),
    .o_sf_active  (o_sf_active),
    .o_sym_done   (o_sym_done),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic start, input logic abort,
                                input logic [1:0] sf, input logic valid,
                                input logic ready);
    i_start      = start;
    i_abort      = abort;
    i_sf_code    = sf;
    i_chip_valid = valid;
    i_chip_ready = ready;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    check_output({tag, "_take"},  32'(o_chip_take),  32'd0);
    check_output({tag, "_idx"},   32'(o_chip_index), 32'd0);
    check_output({tag, "_ref"},   32'(o_ref_phase),  32'd0);
    check_output({tag, "_sym"},   32'(o_sym_index),  32'd0);
    check_output({tag, "_sf"},    32'(o_sf_active),  32'd0);
    check_output({tag, "_sdone"}, 32'(o_sym_done),   32'd0);
    check_output({tag, "_fdone"}, 32'(o_frame_done), 32'd0);
    check_output({tag, "_busy"},  32'(o_busy),       32'd0);
  endtask

  initial begin
    int e_idx;
    int e_sym;
    int e_sd;
    logic rdy;
    checks = 0;
    errors = 0;

    // Reset values
    i_arst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    check_all_reset("rst");
    #11;
    i_arst_n = 1'b1;
    cyc();

    // SF2 full frame: start in cycle 0, takes in cycles 1..32
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    #1;
    check_output("sf2_c0_busy", 32'(o_busy), 32'd0);
    check_output("sf2_c0_take", 32'(o_chip_take), 32'd0);
    cyc();
    i_start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      check_output("sf2_idx",   32'(o_chip_index), 32'((k - 1) % 4));
      check_output("sf2_ref",   32'(o_ref_phase),  32'(((k - 1) % 4) < 2));
      check_output("sf2_take",  32'(o_chip_take),  32'd1);
      check_output("sf2_sym",   32'(o_sym_index),  32'((k - 1) / 4));
      check_output("sf2_sdone", 32'(o_sym_done),   32'(k > 1 && ((k - 1) % 4) == 0));
      check_output("sf2_fdone", 32'(o_frame_done), 32'd0);
      cyc();
    end
    // Cycle 33: frame completion, block idle again
    check_output("sf2_c33_sdone", 32'(o_sym_done),   32'd1);
    check_output("sf2_c33_fdone", 32'(o_frame_done), 32'd1);
    check_output("sf2_c33_busy",  32'(o_busy),       32'd0);
    check_output("sf2_c33_take",  32'(o_chip_take),  32'd0);
    check_output("sf2_c33_idx",   32'(o_chip_index), 32'd0);
    check_output("sf2_c33_sym",   32'(o_sym_index),  32'd0);

    // SF16 started in the completion cycle (back-to-back frame)
    apply_stimulus(1'b1, 1'b0, 2'd3, 1'b1, 1'b1);
    cyc();
    i_start = 1'b0;
    check_output("sf16_busy", 32'(o_busy),      32'd1);
    check_output("sf16_sf",   32'(o_sf_active), 32'd3);
    for (int j = 0; j < 32; j++) begin
      check_output("sf16_idx",   32'(o_chip_index), 32'(j));
      check_output("sf16_ref",   32'(o_ref_phase),  32'(j < 16));
      check_output("sf16_sym",   32'(o_sym_index),  32'd0);
      check_output("sf16_sdone", 32'(o_sym_done),   32'd0);
      cyc();
    end
    check_output("sf16_wrap_idx",   32'(o_chip_index), 32'd0);
    check_output("sf16_wrap_sym",   32'(o_sym_index),  32'd1);
    check_output("sf16_wrap_sdone", 32'(o_sym_done),   32'd1);
    check_output("sf16_wrap_fdone", 32'(o_frame_done), 32'd0);
    check_output("sf16_wrap_busy",  32'(o_busy),       32'd1);
    i_abort = 1'b1;
    #1;
    check_output("sf16_abort_take", 32'(o_chip_take), 32'd0);
    cyc();
    i_abort = 1'b0;
    check_output("sf16_abort_busy",  32'(o_busy),       32'd0);
    check_output("sf16_abort_idx",   32'(o_chip_index), 32'd0);
    check_output("sf16_abort_sym",   32'(o_sym_index),  32'd0);
    check_output("sf16_abort_sdone", 32'(o_sym_done),   32'd0);
    check_output("sf16_abort_sf",    32'(o_sf_active),  32'd3);

    // SF4 with i_chip_ready toggling every cycle
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    cyc();
    i_start = 1'b0;
    e_idx = 0;
    e_sym = 0;
    e_sd  = 0;
    for (int i = 0; i < 18; i++) begin
      rdy = ((i % 2) == 0);
      i_chip_ready = rdy;
      #1;
      check_output("stall_idx",   32'(o_chip_index), 32'(e_idx));
      check_output("stall_sym",   32'(o_sym_index),  32'(e_sym));
      check_output("stall_take",  32'(o_chip_take),  32'(rdy));
      check_output("stall_sdone", 32'(o_sym_done),   32'(e_sd));
      check_output("stall_ref",   32'(o_ref_phase),  32'(e_idx < 4));
      e_sd = 0;
      if (rdy) begin
        if (e_idx == 7) begin
          e_idx = 0;
          e_sym++;
          e_sd = 1;
        end else begin
          e_idx++;
        end
      end
      cyc();
    end
    i_chip_ready = 1'b1;
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;

    // SF code changes from 1 to 3 at chip 2 of an SF4 symbol
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    cyc();
    i_start = 1'b0;
    check_output("sfchg_idx0", 32'(o_chip_index), 32'd0);
    cyc();
    cyc();
    check_output("sfchg_idx2", 32'(o_chip_index), 32'd2);
    i_sf_code = 2'd3;
    for (int c = 2; c < 8; c++) begin
      check_output("sfchg_hold_sf", 32'(o_sf_active), 32'd1);
      cyc();
    end
    check_output("sfchg_wrap_idx",   32'(o_chip_index), 32'd0);
    check_output("sfchg_wrap_sym",   32'(o_sym_index),  32'd1);
    check_output("sfchg_wrap_sdone", 32'(o_sym_done),   32'd1);
    check_output("sfchg_new_sf",     32'(o_sf_active),  32'd3);
    for (int c = 0; c < 8; c++) cyc();
    check_output("sfchg_idx8", 32'(o_chip_index), 32'd8);
    check_output("sfchg_ref8", 32'(o_ref_phase),  32'd1);
    check_output("sfchg_sym8", 32'(o_sym_index),  32'd1);
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;

    // Abort at chip 5 of symbol 3 (SF4), with an ignored start during RUN
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    cyc();
    i_start = 1'b0;
    for (int t = 0; t < 29; t++) begin
      i_start = (t == 10);
      cyc();
    end
    i_start = 1'b0;
    check_output("abort_pre_idx",  32'(o_chip_index), 32'd5);
    check_output("abort_pre_sym",  32'(o_sym_index),  32'd3);
    check_output("abort_pre_busy", 32'(o_busy),       32'd1);
    i_abort = 1'b1;
    #1;
    check_output("abort_take", 32'(o_chip_take), 32'd0);
    cyc();
    i_abort = 1'b0;
    check_output("abort_busy",  32'(o_busy),       32'd0);
    check_output("abort_idx",   32'(o_chip_index), 32'd0);
    check_output("abort_sym",   32'(o_sym_index),  32'd0);
    check_output("abort_sdone", 32'(o_sym_done),   32'd0);
    check_output("abort_fdone", 32'(o_frame_done), 32'd0);
    check_output("abort_sf",    32'(o_sf_active),  32'd1);
    cyc();
    check_output("abort_after_sdone", 32'(o_sym_done),   32'd0);
    check_output("abort_after_fdone", 32'(o_frame_done), 32'd0);

    // Reset asserted mid-frame, then start together with abort
    apply_stimulus(1'b1, 1'b0, 2'd2, 1'b1, 1'b1);
    cyc();
    i_start = 1'b0;
    cyc();
    cyc();
    check_output("mrst_pre_idx", 32'(o_chip_index), 32'd2);
    #2;
    i_arst_n = 1'b0;
    #1;
    check_all_reset("mrst");
    #2;
    i_arst_n = 1'b1;
    cyc();
    check_output("mrst_post_busy", 32'(o_busy), 32'd0);
    apply_stimulus(1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
    #1;
    check_output("sa_take", 32'(o_chip_take), 32'd0);
    cyc();
    apply_stimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    #1;
    check_output("sa_busy", 32'(o_busy),       32'd0);
    check_output("sa_idx",  32'(o_chip_index), 32'd0);
    check_output("sa_sf",   32'(o_sf_active),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
